// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: op codes, PSW layout, masks, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    ADDC = 4'd1,
    SUB  = 4'd2,
    SUBC = 4'd3,
    DADD = 4'd4,
    XOR  = 4'd5,
    AND  = 4'd6,
    OR   = 4'd7,
    BIT  = 4'd8,
    BIC  = 4'd9,
    BIS  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BCD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned PSW_W = 16;
  localparam int unsigned PSW_C = 0;
  localparam int unsigned PSW_Z = 1;
  localparam int unsigned PSW_N = 2;
  localparam int unsigned PSW_V = 4;

  localparam logic [PSW_W-1:0] MSK_ARITH = 16'h0017;
  localparam logic [PSW_W-1:0] MSK_LOGIC = 16'h0006;
  localparam logic [PSW_W-1:0] MSK_DADD  = 16'h0007;

  // Pack individual flags into their PSW bit positions.
  function automatic logic [PSW_W-1:0] mk_psw(input logic c, input logic z,
                                                input logic n, input logic v);
    logic [PSW_W-1:0] p;
    p        = '0;
    p[PSW_C] = c;
    p[PSW_Z] = z;
    p[PSW_N] = n;
    p[PSW_V] = v;
    return p;
  endfunction

endpackage

// File: rtl/alu_bcd_digit.sv
// One packed-BCD digit adder: digit_a + digit_b + cin with decimal carry out.
module alu_bcd_digit (
  input  logic [3:0] digit_a,
  input  logic [3:0] digit_b,
  input  logic       cin,
  output logic [3:0] digit_sum,
  output logic       cout
);

  logic [4:0] raw;

  // Binary add, then +6 correction when the digit exceeds 9.
  always_comb begin
    raw       = 5'(digit_a) + 5'(digit_b) + 5'(cin);
    cout      = (raw > 5'd9);
    digit_sum = cout ? 4'(raw + 5'd6) : raw[3:0];
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides and registered result/PSW.
// Optional decimal add (one BCD digit per cycle) is built only when ALU_SEQ_DADD_EN is defined;
// otherwise DADD behaves as an undefined op.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [15:0]      psw_out,
  output logic [15:0]      psw_msk
);

  state_e           state;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] res_c;
  logic             c_c;
  logic             v_c;
  logic [15:0]      msk_c;
  logic [15:0]      psw_c;

  // A new op is taken when idle, or when the current result is consumed this cycle.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Shared adder: subtraction is a + ~b + carry.
  always_comb begin
    b_eff   = b;
    cin_eff = 1'b0;
    case (op)
      ADDC:    cin_eff = carry_in;
      SUB:     begin b_eff = ~b; cin_eff = 1'b1;     end
      SUBC:    begin b_eff = ~b; cin_eff = carry_in; end
      default: ;
    endcase
    sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
  end

  // Single-cycle result and flags for every op except decimal add.
  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    msk_c = '0;
    case (op)
      ADD, ADDC, SUB, SUBC: begin
        res_c = sum_ext[WIDTH-1:0];
        c_c   = sum_ext[WIDTH];
        v_c   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
        msk_c = MSK_ARITH;
      end
      AND, BIT: begin res_c = a & b;  msk_c = MSK_LOGIC; end
      OR, BIS:  begin res_c = a | b;  msk_c = MSK_LOGIC; end
      XOR:      begin res_c = a ^ b;  msk_c = MSK_LOGIC; end
      BIC:      begin res_c = a & ~b; msk_c = MSK_LOGIC; end
      default:  ;
    endcase
    psw_c = mk_psw(c_c, res_c == '0, res_c[WIDTH-1], v_c) & msk_c;
  end

`ifdef ALU_SEQ_DADD_EN
  localparam int unsigned NDIG  = WIDTH / 4;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-5:0] sum_q;
  logic [WIDTH-1:0] bcd_next;
  logic             dcarry_q;
  logic [3:0]       dsum;
  logic             dcout;
  logic [CNT_W-1:0] cnt_q;

  alu_bcd_digit u_digit (
    .digit_a   (a_q[3:0]),
    .digit_b   (b_q[3:0]),
    .cin       (dcarry_q),
    .digit_sum (dsum),
    .cout      (dcout)
  );

  // New digit enters at the top; after the last digit the sum is fully aligned.
  assign bcd_next = {dsum, sum_q};
`endif

  // Handshake FSM with registered outputs and, when enabled, the digit-serial BCD datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      psw_out   <= '0;
      psw_msk   <= '0;
`ifdef ALU_SEQ_DADD_EN
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      dcarry_q  <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_SEQ_DADD_EN
            if (op == DADD) begin
              state     <= BCD;
              out_valid <= 1'b0;
              a_q       <= a;
              b_q       <= b;
              sum_q     <= '0;
              dcarry_q  <= carry_in;
              cnt_q     <= '0;
            end else begin
`else
            begin
`endif
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= res_c;
              psw_out   <= psw_c;
              psw_msk   <= msk_c;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_SEQ_DADD_EN
        BCD: begin
          a_q      <= a_q >> 4;
          b_q      <= b_q >> 4;
          sum_q    <= bcd_next[WIDTH-1:4];
          dcarry_q <= dcout;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NDIG - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= bcd_next;
            psw_out   <= mk_psw(dcout, bcd_next == '0, bcd_next[WIDTH-1], 1'b0) & MSK_DADD;
            psw_msk   <= MSK_DADD;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed vector table, handshake/reset sequences,
// and random ops against an integer reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 16;
`ifdef ALU_SEQ_DADD_EN
  localparam bit DADD_EN = 1'b1;
`else
  localparam bit DADD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  alu_op_e       op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          carry_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [15:0]   psw_out;
  logic [15:0]   psw_msk;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .psw_out   (psw_out),
    .psw_msk   (psw_msk)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned op;
    int unsigned a;
    int unsigned b;
    int unsigned cin;
    int unsigned r;
    int unsigned p;
    int unsigned m;
    int unsigned lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input string n, input int unsigned o, x, y, ci,
                                  input int unsigned r, p, m, lat);
    vec_t v;
    v.name = n; v.op = o; v.a = x; v.b = y; v.cin = ci;
    v.r = r; v.p = p; v.m = m; v.lat = lat;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", n, got, exp);
    end
  endtask

  function automatic int s16(input int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  // Reference: integer arithmetic straight from the op definitions.
  function automatic void model(input int unsigned o, x, y, ci,
                                output int unsigned r, p, m, lat);
    int unsigned bx, cc, s, carry;
    bit c, v;
    int ss;
    r = 0; p = 0; m = 0; lat = 1; c = 0; v = 0;
    case (o)
      0, 1, 2, 3: begin
        bx = (o >= 2) ? (~y & 32'hFFFF) : y;
        cc = (o == 0) ? 0 : (o == 2) ? 1 : ci;
        s  = x + bx + cc;
        r  = s & 32'hFFFF;
        c  = (s >> 16) != 0;
        ss = s16(x) + s16(bx) + int'(cc);
        v  = (ss > 32767) || (ss < -32768);
        m  = 32'h17;
      end
      4: if (DADD_EN) begin
        carry = ci;
        for (int d = 0; d < 4; d++) begin
          int unsigned sd;
          sd = ((x >> (4 * d)) & 15) + ((y >> (4 * d)) & 15) + carry;
          if (sd > 9) begin sd = sd - 10; carry = 1; end else carry = 0;
          r = r | ((sd & 15) << (4 * d));
        end
        c = carry != 0;
        m = 32'h7;
        lat = 5;
      end
      5:     begin r = x ^ y;            m = 32'h6; end
      6, 8:  begin r = x & y;            m = 32'h6; end
      7, 10: begin r = x | y;            m = 32'h6; end
      9:     begin r = x & ~y & 32'hFFFF; m = 32'h6; end
      default: ;
    endcase
    if (c)                 p = p | 32'h01;
    if (r == 0)            p = p | 32'h02;
    if (((r >> 15) & 1) != 0) p = p | 32'h04;
    if (v)                 p = p | 32'h10;
    p = p & m;
  endfunction

  // Issue one op, scramble inputs after accept, return the first valid result and its latency.
  task automatic run_op(input int unsigned o, x, y, ci,
                        output logic [15:0] r, p, m, output int lat);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
    op       = alu_op_e'(o[3:0]);
    a        = x[15:0];
    b        = y[15:0];
    carry_in = ci[0];
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    carry_in = 1'($urandom);
    op       = alu_op_e'(4'($urandom));
    lat = -1; r = '0; p = '0; m = '0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid) begin
        lat = i; r = result; p = psw_out; m = psw_msk;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] r, p, m;
    int          lat;
    int unsigned er, ep, em, el;
    logic [15:0] va [4];
    logic [15:0] vb [4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = ADD; a = '0; b = '0; carry_in = 1'b0;

    add_vec("add_ovf",  0, 16'h7FFF, 16'h0001, 0, 16'h8000, 16'h0014, 16'h0017, 1);
    add_vec("sub_zero", 2, 16'h0005, 16'h0005, 0, 16'h0000, 16'h0003, 16'h0017, 1);
    add_vec("subc_c0",  3, 16'h0005, 16'h0005, 0, 16'hFFFF, 16'h0004, 16'h0017, 1);
    add_vec("addc_c1",  1, 16'hFFFF, 16'h0000, 1, 16'h0000, 16'h0003, 16'h0017, 1);
    add_vec("sub_ovf",  2, 16'h8000, 16'h0001, 0, 16'h7FFF, 16'h0011, 16'h0017, 1);
    add_vec("and",      6, 16'hF0F0, 16'h0FF0, 0, 16'h00F0, 16'h0000, 16'h0006, 1);
    add_vec("xor",      5, 16'hFFFF, 16'h0001, 0, 16'hFFFE, 16'h0004, 16'h0006, 1);
    add_vec("or_zero",  7, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0002, 16'h0006, 1);
    add_vec("bit",      8, 16'h1234, 16'h4321, 0, 16'h0220, 16'h0000, 16'h0006, 1);
    add_vec("bic",      9, 16'h00FF, 16'h00FF, 0, 16'h0000, 16'h0002, 16'h0006, 1);
    add_vec("bis",     10, 16'h8000, 16'h0001, 0, 16'h8001, 16'h0004, 16'h0006, 1);
    add_vec("undef12", 12, 16'h1234, 16'h5678, 0, 16'h0000, 16'h0000, 16'h0000, 1);
    add_vec("undef15", 15, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 16'h0000, 16'h0000, 1);
`ifdef ALU_SEQ_DADD_EN
    add_vec("dadd_0999", 4, 16'h0999, 16'h0001, 0, 16'h1000, 16'h0000, 16'h0007, 5);
    add_vec("dadd_9999", 4, 16'h9999, 16'h0001, 0, 16'h0000, 16'h0003, 16'h0007, 5);
    add_vec("dadd_1_1",  4, 16'h0001, 16'h0001, 0, 16'h0002, 16'h0000, 16'h0007, 5);
    add_vec("dadd_cin",  4, 16'h0000, 16'h0000, 1, 16'h0001, 16'h0000, 16'h0007, 5);
`else
    add_vec("dadd_0999", 4, 16'h0999, 16'h0001, 0, 16'h0000, 16'h0000, 16'h0000, 1);
    add_vec("dadd_1_1",  4, 16'h0001, 16'h0001, 0, 16'h0000, 16'h0000, 16'h0000, 1);
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_psw",       32'(psw_out),   32'd0);
    chk("rst_msk",       32'(psw_msk),   32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, r, p, m, lat);
      chk({vecs[i].name, "_res"}, 32'(r),   32'(vecs[i].r));
      chk({vecs[i].name, "_psw"}, 32'(p),   32'(vecs[i].p));
      chk({vecs[i].name, "_msk"}, 32'(m),   32'(vecs[i].m));
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held while out_ready is low, then four back-to-back ANDs
    @(negedge clk);
    out_ready = 1'b0;
    op = ADD; a = 16'h1111; b = 16'h2222; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_res", k),   32'(result),    32'h3333);
      chk($sformatf("bp_hold%0d_ready", k), 32'(in_ready),  32'd0);
      @(negedge clk);
    end
    va[0] = 16'hFF00; vb[0] = 16'h0FF0;
    va[1] = 16'h1234; vb[1] = 16'hFFFF;
    va[2] = 16'h8001; vb[2] = 16'h8003;
    va[3] = 16'hAAAA; vb[3] = 16'h0F0F;
    out_ready = 1'b1;
    op = AND; a = va[0]; b = vb[0]; in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d_valid", j), 32'(out_valid), 32'd1);
      chk($sformatf("b2b%0d_res", j),   32'(result),    32'(va[j] & vb[j]));
      if (j < 3) begin
        a = va[j+1]; b = vb[j+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_drain_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a decimal add
    op = ADD; a = 16'h4000; b = 16'h0321; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = DADD; a = 16'h1234; b = 16'h1111; carry_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid",  32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result),    32'd0);
    chk("midrst_psw",    32'(psw_out),   32'd0);
    chk("midrst_msk",    32'(psw_msk),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(in_ready),  32'd1);
    chk("postrst_valid",    32'(out_valid), 32'd0);
    run_op(0, 16'h0102, 16'h0304, 0, r, p, m, lat);
    chk("postrst_add_res", 32'(r),   32'h0406);
    chk("postrst_add_psw", 32'(p),   32'h0000);
    chk("postrst_add_msk", 32'(m),   32'h0017);
    chk("postrst_add_lat", 32'(lat), 32'd1);

    // Random ops against the model
    for (int i = 0; i < 150; i++) begin
      int unsigned o, x, y, ci;
      o  = $urandom_range(0, 15);
      x  = $urandom & 32'hFFFF;
      y  = $urandom & 32'hFFFF;
      ci = $urandom_range(0, 1);
      model(o, x, y, ci, er, ep, em, el);
      run_op(o, x, y, ci, r, p, m, lat);
      chk($sformatf("rnd%0d_op%0d_res", i, o), 32'(r),   32'(er));
      chk($sformatf("rnd%0d_op%0d_psw", i, o), 32'(p),   32'(ep));
      chk($sformatf("rnd%0d_op%0d_msk", i, o), 32'(m),   32'(em));
      chk($sformatf("rnd%0d_op%0d_lat", i, o), 32'(lat), 32'(el));
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
